// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//   Shared types and helpers for the serial magnitude comparator.
//   - state_t   : FSM encoding (IDLE / SHIFT / DONE)
//   - cnt_width : bit-counter width for a given operand width, never below 1
// ---------------------------------------------------------------------------
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // $clog2(1) is 0, so a 1-bit operand still gets a 1-bit counter.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 32'd1) ? 32'd1 : 32'($clog2(width));
   endfunction

endpackage

// File: rtl/comparator_1bit.sv
// ---------------------------------------------------------------------------
// comparator_1bit
//   Single-bit magnitude compare cell.
//   Ports:
//     a_i, b_i  in   operand bits
//     lt_o      out  a_i < b_i
//     eq_o      out  a_i == b_i
//     gt_o      out  a_i > b_i
// ---------------------------------------------------------------------------
module comparator_1bit (
   input  logic a_i,
   input  logic b_i,
   output logic lt_o,
   output logic eq_o,
   output logic gt_o
);

   always_comb begin
      lt_o = ~a_i &  b_i;
      gt_o =  a_i & ~b_i;
      eq_o = ~(a_i ^ b_i);
   end

endmodule

// File: rtl/serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// serial_mag_comparator
//   Multi-cycle magnitude comparator. Operands are captured on an accepted
//   start and walked MSB-first through one comparator_1bit cell. Results are
//   registered and held until the next done pulse.
//
//   Parameter:
//     WIDTH   operand width, 1..32
//   Ports:
//     clk     in   clock, rising edge
//     rst_n   in   asynchronous active-low reset
//     start   in   request, sampled only while not busy
//     a, b    in   operands, sampled on the accepted start edge
//     busy    out  high while bits are being compared
//     done    out  one-cycle pulse when lt/eq/gt update
//     lt      out  A < B
//     eq      out  A == B
//     gt      out  A > B
//
//   Build option:
//     EARLY_EXIT_EN  when defined, finish on the first differing bit instead
//                    of always walking all WIDTH bits. Results are unchanged.
// ---------------------------------------------------------------------------
module serial_mag_comparator
   import cmp_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   localparam int unsigned CNT_W = cnt_width(WIDTH);

`ifdef EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_t           state_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;
   logic [CNT_W-1:0] cnt_q;
   logic             w_lt_q;
   logic             w_gt_q;
   logic             lt_q;
   logic             eq_q;
   logic             gt_q;
   logic             busy_q;
   logic             done_q;

   logic             bit_lt;
   logic             bit_gt;
   logic             bit_eq_unused;
   logic             w_lt_d;
   logic             w_gt_d;
   logic             finish_d;

   comparator_1bit u_cell (
      .a_i  (sa_q[WIDTH-1]),
      .b_i  (sb_q[WIDTH-1]),
      .lt_o (bit_lt),
      .eq_o (bit_eq_unused),
      .gt_o (bit_gt)
   );

   // The first differing bit decides the result; later bits must not
   // override it, so the working flags freeze once either is set.
   always_comb begin
      w_lt_d = w_lt_q;
      w_gt_d = w_gt_q;
      if (!(w_lt_q || w_gt_q)) begin
         w_lt_d = bit_lt;
         w_gt_d = bit_gt;
      end
      finish_d = (cnt_q == '0) || (EARLY_EXIT && (w_lt_d || w_gt_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         w_lt_q  <= 1'b0;
         w_gt_q  <= 1'b0;
         lt_q    <= 1'b0;
         eq_q    <= 1'b0;
         gt_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  w_lt_q  <= 1'b0;
                  w_gt_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end

            SHIFT: begin
               w_lt_q <= w_lt_d;
               w_gt_q <= w_gt_d;
               sa_q   <= sa_q << 1;
               sb_q   <= sb_q << 1;
               cnt_q  <= cnt_q - CNT_W'(1);
               if (finish_d) begin
                  lt_q    <= w_lt_d;
                  gt_q    <= w_gt_d;
                  eq_q    <= ~(w_lt_d | w_gt_d);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end

            DONE: begin
               done_q <= 1'b0;
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  cnt_q   <= CNT_W'(WIDTH - 1);
                  w_lt_q  <= 1'b0;
                  w_gt_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  state_q <= IDLE;
               end
            end

            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign lt   = lt_q;
   assign eq   = eq_q;
   assign gt   = gt_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// ---------------------------------------------------------------------------
// tb_serial_mag_comparator
//   Scoreboard bench for serial_mag_comparator at WIDTH=3. Stimulus pushes the
//   expected result and busy-cycle count; a monitor pops on every done pulse.
//   Honours EARLY_EXIT_EN for the expected busy-cycle counts.
// ---------------------------------------------------------------------------
module tb_serial_mag_comparator;

   localparam int unsigned WIDTH = 3;
`ifdef EARLY_EXIT_EN
   localparam bit EE = 1'b1;
`else
   localparam bit EE = 1'b0;
`endif

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b1;
   logic [WIDTH-1:0] a     = '0;
   logic [WIDTH-1:0] b     = '0;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;

   serial_mag_comparator #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .lt    (lt),
      .eq    (eq),
      .gt    (gt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int   tag;
      logic lt;
      logic eq;
      logic gt;
      int   busy;
   } exp_t;

   exp_t sbq[$];
   int   checks   = 0;
   int   failures = 0;
   int   busy_cnt = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Busy cycles with early exit: count down from the MSB to the first
   // differing bit; equal operands walk every bit.
   function automatic int exp_busy(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      if (!EE) return WIDTH;
      for (int i = WIDTH - 1; i >= 0; i--)
         if (x[i] != y[i]) return WIDTH - i;
      return WIDTH;
   endfunction

   // Monitor: count busy cycles, pop and compare on each done pulse.
   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (sbq.size() == 0) begin
               chk("spurious_done", 32'(done), 32'd0);
            end else begin
               e = sbq.pop_front();
               chk($sformatf("lt[%0d]", e.tag),   32'(lt), 32'(e.lt));
               chk($sformatf("eq[%0d]", e.tag),   32'(eq), 32'(e.eq));
               chk($sformatf("gt[%0d]", e.tag),   32'(gt), 32'(e.gt));
               chk($sformatf("busy_cycles[%0d]", e.tag), 32'(busy_cnt), 32'(e.busy));
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input bit push,
                        input logic elt, input logic eeq, input logic egt, input int ebusy,
                        input int tag);
      int n = 0;
      while (busy && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) chk($sformatf("issue_busy_timeout[%0d]", tag), 32'(busy), 32'd0);
      if (push) sbq.push_back('{tag, elt, eeq, egt, ebusy});
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int tag);
      int n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!done && n < 40);
      if (!done) chk($sformatf("done_timeout[%0d]", tag), 32'(done), 32'd1);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      // 1. Reset held with start high: everything stays quiet.
      repeat (3) begin
         @(negedge clk);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_lt",   32'(lt),   32'd0);
         chk("rst_eq",   32'(eq),   32'd0);
         chk("rst_gt",   32'(gt),   32'd0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_eq",   32'(eq),   32'd0);
      @(posedge clk); #1;

      // 2..4. Directed vectors.
      issue(3'b100, 3'b001, 1'b1, 1'b0, 1'b0, 1'b1, EE ? 1 : 3, 2);
      wait_done(2);
      issue(3'b101, 3'b101, 1'b1, 1'b0, 1'b1, 1'b0, 3, 3);
      wait_done(3);
      issue(3'b010, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0, 3, 4);
      wait_done(4);

      // 5. start mid-SHIFT is ignored; start in the DONE cycle is accepted.
      issue(3'b110, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3, 50);
      a     = 3'b000;
      b     = 3'b111;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      a     = 3'b111;
      b     = 3'b000;
      wait_done(50);
      chk("done_cycle_busy", 32'(busy), 32'd0);
      issue(3'b011, 3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 3, 51);
      wait_done(51);

      // 6. Reset on the second SHIFT cycle: immediate clear, no done.
      issue(3'b101, 3'b100, 1'b0, 1'b0, 1'b0, 1'b0, 0, 60);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_lt",   32'(lt),   32'd0);
      chk("midrst_eq",   32'(eq),   32'd0);
      chk("midrst_gt",   32'(gt),   32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("after_midrst_done", 32'(done), 32'd0);
         chk("after_midrst_busy", 32'(busy), 32'd0);
      end
      @(posedge clk); #1;
      issue(3'b101, 3'b100, 1'b1, 1'b0, 1'b0, 1'b1, 3, 61);
      wait_done(61);

      // Exhaustive sweep of all operand pairs.
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            logic [WIDTH-1:0] x;
            logic [WIDTH-1:0] y;
            x = WIDTH'(i);
            y = WIDTH'(j);
            issue(x, y, 1'b1, (i < j), (i == j), (i > j), exp_busy(x, y), 100 + i * 8 + j);
            wait_done(100 + i * 8 + j);
         end
      end

      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
